// File: rtl/fir_wb_arbiter_if.sv
// rtl/fir_wb_arbiter_if.sv - Wishbone signal bundle joining two masters, the arbiter and the FIR slave
//
// Purpose: carries every bus signal of the two-master FIR arbiter so the arbiter
// takes a single port. Signal names follow the arbiter's own direction (_i into
// the arbiter, _o out of it).
// Modports:
//   slave  - arbiter view: master requests and slave responses in, muxed bus out
//   master - environment view (masters plus FIR slave): the opposite directions
// Parameters: AW address width, DW data width, SW byte-select width (DW/8).
interface fir_wb_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = 4
);
    logic          m0_cyc_i;
    logic          m0_stb_i;
    logic          m0_we_i;
    logic [SW-1:0] m0_sel_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o;

    logic          m1_cyc_i;
    logic          m1_stb_i;
    logic          m1_we_i;
    logic [SW-1:0] m1_sel_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o;

    logic          s_cyc_o;
    logic          s_stb_o;
    logic          s_we_o;
    logic [SW-1:0] s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;

    logic [1:0]    grant_o;
    logic          timeout_o;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        output m0_dat_o, m0_ack_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        output m1_dat_o, m1_ack_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_dat_i, s_ack_i,
        output grant_o, timeout_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        input  m0_dat_o, m0_ack_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        input  m1_dat_o, m1_ack_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_dat_i, s_ack_i,
        input  grant_o, timeout_o
    );
endinterface

// File: rtl/fir_wb_arbiter.sv
// rtl/fir_wb_arbiter.sv - two-master round-robin Wishbone arbiter in front of the FIR slave
//
// Purpose: grants the FIR slave to one master for the whole of its cyc, routes
// ack/read data back only to the granted master, and alternates on contention.
// Ports:
//   wb_clk_i  - clock, all state on the rising edge
//   wb_rst_i  - asynchronous active-high reset
//   bus       - fir_wb_arbiter_if.slave: m0_*/m1_* requesters, s_* FIR slave,
//               grant_o one-hot {m1,m0} (00 idle), timeout_o sticky timeout flag
// Optional feature macro: FIR_ARB_TIMEOUT_EN - stall counter that forces an ack
// with 32'hDEAD_BEEF after TIMEOUT_CYC stalled strobe cycles; when undefined,
// timeout_o is tied 0.
module fir_wb_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int SW          = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    fir_wb_arbiter_if.slave    bus
);
    // Encoding equals the one-hot grant so the state register drives grant_o.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last_grant;
    logic          w_ack_in;
    logic          w_force;
    logic [DW-1:0] w_force_dat;

    assign w_force_dat = DW'(32'hDEAD_BEEF);

    // State register; last_grant records whoever just finished a cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == GNT0 && !bus.m0_cyc_i) begin
                r_last_grant <= 1'b0;
            end else if (r_state == GNT1 && !bus.m1_cyc_i) begin
                r_last_grant <= 1'b1;
            end
        end
    end

    // Next state: the cyc lock means no preemption; on release the other
    // requester takes over directly without passing through IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    w_next = r_last_grant ? GNT0 : GNT1;
                end else if (bus.m0_cyc_i) begin
                    w_next = GNT0;
                end else if (bus.m1_cyc_i) begin
                    w_next = GNT1;
                end
            end
            GNT0: begin
                if (!bus.m0_cyc_i) begin
                    w_next = bus.m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!bus.m1_cyc_i) begin
                    w_next = bus.m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

`ifdef FIR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_to_cnt;
    logic          r_ignore;
    logic          r_timeout;
    logic          w_stb_g;

    assign w_stb_g  = (r_state == GNT0 && bus.m0_stb_i) || (r_state == GNT1 && bus.m1_stb_i);
    // A slave ack landing right after a forced completion belongs to the
    // abandoned beat, so it is masked for one cycle.
    assign w_ack_in = bus.s_ack_i & ~r_ignore;
    assign w_force  = (r_state != IDLE) && (r_to_cnt == CW'(TIMEOUT_CYC));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_to_cnt  <= '0;
            r_ignore  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_ignore <= w_force && (w_next == r_state);
            if (w_force) begin
                r_timeout <= 1'b1;
            end
            if (w_force || w_ack_in || (w_next != r_state) || (r_state == IDLE)) begin
                r_to_cnt <= '0;
            end else if (w_stb_g) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign bus.timeout_o = r_timeout;
`else
    logic w_unused_cfg;

    assign w_ack_in      = bus.s_ack_i;
    assign w_force       = 1'b0;
    assign bus.timeout_o = 1'b0;
    assign w_unused_cfg  = (TIMEOUT_CYC == 0) | (^w_force_dat);
`endif

    assign bus.grant_o = r_state;

    // Slave mux and return path, both gated purely by the current grant.
    always_comb begin
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_we_o   = 1'b0;
        bus.s_sel_o  = '0;
        bus.s_adr_o  = '0;
        bus.s_dat_o  = '0;
        bus.m0_ack_o = 1'b0;
        bus.m0_dat_o = '0;
        bus.m1_ack_o = 1'b0;
        bus.m1_dat_o = '0;
        case (r_state)
            GNT0: begin
                bus.s_cyc_o  = bus.m0_cyc_i;
                bus.s_stb_o  = bus.m0_stb_i & ~w_force;
                bus.s_we_o   = bus.m0_we_i;
                bus.s_sel_o  = bus.m0_sel_i;
                bus.s_adr_o  = bus.m0_adr_i;
                bus.s_dat_o  = bus.m0_dat_i;
                bus.m0_ack_o = w_ack_in | w_force;
                bus.m0_dat_o = w_force ? w_force_dat : bus.s_dat_i;
            end
            GNT1: begin
                bus.s_cyc_o  = bus.m1_cyc_i;
                bus.s_stb_o  = bus.m1_stb_i & ~w_force;
                bus.s_we_o   = bus.m1_we_i;
                bus.s_sel_o  = bus.m1_sel_i;
                bus.s_adr_o  = bus.m1_adr_i;
                bus.s_dat_o  = bus.m1_dat_i;
                bus.m1_ack_o = w_ack_in | w_force;
                bus.m1_dat_o = w_force ? w_force_dat : bus.s_dat_i;
            end
            default: begin
            end
        endcase
    end
endmodule
